kick_sequencer: RTL and testbench

//  Sequences the kicker pulse generator. Accepts kick commands from the radio/SPI path: immediate kick, arm-on-break-beam, or disarm.

---
 rtl/kicker_pkg.sv | 20 ++
 rtl/debounce_filter.sv | 54 +++++
 rtl/kick_sequencer.sv | 160 ++++++++++++++++
 tb/tb_kick_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kicker_pkg.sv
// Shared encodings for the kick sequencer: host command opcodes and FSM states.
package kicker_pkg;

    typedef enum logic [1:0] {
        CmdKickNow  = 2'b00,
        CmdArm      = 2'b01,
        CmdDisarm   = 2'b10,
        CmdReserved = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StArmed     = 3'd1,
        StWaitReady = 3'd2,
        StStrobe    = 3'd3,
        StWaitFire  = 3'd4,
        StWaitDone  = 3'd5
    } state_e;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a stable-count filter; the filtered level only
// changes after the synchronised input has disagreed with it for CYCLES consecutive clocks.
module debounce_filter #(
    parameter int unsigned CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int unsigned CntW = $clog2(CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CYCLES - 1);

    logic [1:0]      sync_q, sync_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d  = {sync_q[0], din};
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        // Any sample agreeing with the current level restarts the stability count.
        if (sync_q[1] != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = sync_q[1];
                rise_d  = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/kick_sequencer.sv
// Sequences kick commands into single strobes to the kicker pulse generator, handles
// arm-on-break-beam with auto-disarm, strobe-response timeout fault and charge gating.
module kick_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 64,
    parameter logic [23:0] ARM_TIMEOUT     = 24'd9000000,
    parameter logic [15:0] STROBE_TIMEOUT  = 16'd1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_strength,
    input  logic       charge_req,
    input  logic       beam_raw,
    input  logic       kick_fire,
    input  logic       kick_lockout,
    output logic       kick_strobe,
    output logic [7:0] kick_strength,
    output logic       charge_enable,
    output logic       armed,
    output logic       busy,
    output logic       kick_done,
    output logic       fault
);

    import kicker_pkg::*;

    state_e      state_q, state_d;
    logic [7:0]  strength_q, strength_d;
    logic [23:0] arm_cnt_q, arm_cnt_d;
    logic [15:0] strobe_cnt_q, strobe_cnt_d;
    logic        fault_q, fault_d;
    logic        done_q, done_d;
    logic        charge_q, charge_d;

    logic beam_broken, beam_rise;
    logic is_kick, is_arm, is_disarm, kicker_ready, arm_expired;

    debounce_filter #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_beam_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (beam_raw),
        .level (beam_broken),
        .rise  (beam_rise)
    );

    assign is_kick      = cmd_valid && (cmd_op == CmdKickNow);
    assign is_arm       = cmd_valid && (cmd_op == CmdArm);
    assign is_disarm    = cmd_valid && (cmd_op == CmdDisarm);
    assign kicker_ready = !kick_fire && !kick_lockout;
    assign arm_expired  = (ARM_TIMEOUT != 24'd0) && (arm_cnt_q == ARM_TIMEOUT - 24'd1);

    always_comb begin
        state_d      = state_q;
        strength_d   = strength_q;
        arm_cnt_d    = arm_cnt_q;
        strobe_cnt_d = '0;
        fault_d      = fault_q;
        done_d       = 1'b0;

        if (is_disarm) begin
            fault_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (is_kick) begin
                    strength_d = cmd_strength;
                    state_d    = StWaitReady;
                end else if (is_arm) begin
                    strength_d = cmd_strength;
                    arm_cnt_d  = '0;
                    state_d    = StArmed;
                end
            end
            StArmed: begin
                if (arm_cnt_q != 24'hFF_FFFF) begin
                    arm_cnt_d = arm_cnt_q + 24'd1;
                end
                // Valid commands take priority over a coincident beam edge.
                if (is_disarm) begin
                    state_d = StIdle;
                end else if (is_kick) begin
                    strength_d = cmd_strength;
                    state_d    = StWaitReady;
                end else if (is_arm) begin
                    strength_d = cmd_strength;
                    arm_cnt_d  = '0;
                end else if (beam_rise) begin
                    state_d = StWaitReady;
                end else if (arm_expired) begin
                    state_d = StIdle;
                end
            end
            StWaitReady: begin
                if (is_disarm) begin
                    state_d = StIdle;
                end else if (kicker_ready) begin
                    state_d = StStrobe;
                end
            end
            StStrobe: begin
                state_d = StWaitFire;
            end
            StWaitFire: begin
                if (kick_fire) begin
                    state_d = StWaitDone;
                end else if (strobe_cnt_q == STROBE_TIMEOUT - 16'd1) begin
                    fault_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    strobe_cnt_d = strobe_cnt_q + 16'd1;
                end
            end
            StWaitDone: begin
                if (kicker_ready) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy     = (state_q == StWaitReady) || (state_q == StStrobe) ||
                      (state_q == StWaitFire) || (state_q == StWaitDone);
    assign charge_d = charge_req && !busy && !fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            strength_q   <= '0;
            arm_cnt_q    <= '0;
            strobe_cnt_q <= '0;
            fault_q      <= 1'b0;
            done_q       <= 1'b0;
            charge_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            strength_q   <= strength_d;
            arm_cnt_q    <= arm_cnt_d;
            strobe_cnt_q <= strobe_cnt_d;
            fault_q      <= fault_d;
            done_q       <= done_d;
            charge_q     <= charge_d;
        end
    end

    assign kick_strobe   = (state_q == StStrobe);
    assign kick_strength = strength_q;
    assign armed         = (state_q == StArmed);
    assign kick_done     = done_q;
    assign fault         = fault_q;
    assign charge_enable = charge_q;

endmodule

// File: tb/tb_kick_sequencer.sv
// Directed bench for kick_sequencer with a simple kicker model (fire then lockout after a strobe).
module tb_kick_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_valid_t = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_strength = 8'd0;
    logic       charge_req = 1'b0;
    logic       beam_raw = 1'b0;
    logic       kick_fire;
    logic       kick_lockout;

    logic       kick_strobe, charge_enable, armed, busy, kick_done, fault;
    logic [7:0] kick_strength;
    logic       t_strobe, t_charge, t_armed, t_busy, t_done, t_fault;
    logic [7:0] t_strength;

    int checks = 0;
    int failures = 0;

    logic model_en = 1'b0;
    logic force_lock = 1'b0;
    logic mdl_fire = 1'b0;
    logic mdl_lock = 1'b0;
    int   mdl_cnt = 0;

    int         strobe_seen = 0;
    logic [7:0] last_strength = 8'd0;

    always #5 clk = ~clk;

    kick_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_op        (cmd_op),
        .cmd_strength  (cmd_strength),
        .charge_req    (charge_req),
        .beam_raw      (beam_raw),
        .kick_fire     (kick_fire),
        .kick_lockout  (kick_lockout),
        .kick_strobe   (kick_strobe),
        .kick_strength (kick_strength),
        .charge_enable (charge_enable),
        .armed         (armed),
        .busy          (busy),
        .kick_done     (kick_done),
        .fault         (fault)
    );

    kick_sequencer #(
        .ARM_TIMEOUT (24'd100)
    ) dut_t (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid_t),
        .cmd_op        (cmd_op),
        .cmd_strength  (cmd_strength),
        .charge_req    (charge_req),
        .beam_raw      (1'b0),
        .kick_fire     (kick_fire),
        .kick_lockout  (kick_lockout),
        .kick_strobe   (t_strobe),
        .kick_strength (t_strength),
        .charge_enable (t_charge),
        .armed         (t_armed),
        .busy          (t_busy),
        .kick_done     (t_done),
        .fault         (t_fault)
    );

    // Kicker model: fire for 3 cycles, then lockout for 7, after each strobe.
    always @(posedge clk) begin
        #2;
        if (mdl_cnt > 0) mdl_cnt = mdl_cnt - 1;
        else if (kick_strobe === 1'b1 && model_en) mdl_cnt = 10;
        mdl_fire = (mdl_cnt > 7);
        mdl_lock = (mdl_cnt > 0) && (mdl_cnt <= 7);
    end
    assign kick_fire    = mdl_fire;
    assign kick_lockout = mdl_lock | force_lock;

    always @(negedge clk) begin
        if (kick_strobe === 1'b1) begin
            strobe_seen   = strobe_seen + 1;
            last_strength = kick_strength;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] s);
        cmd_valid    = 1'b1;
        cmd_op       = op;
        cmd_strength = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (kick_done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (kick_done !== 1'b1) begin
            failures++;
            $display("FAIL %s: kick_done not seen within %0d cycles (got %b, want 1)", name,
                     budget, kick_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({kick_strobe, charge_enable, armed, busy, kick_done, fault} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {kick_strobe, charge_enable, armed, busy, kick_done, fault});
        end
        checks++;
        if (kick_strength !== 8'd0) begin
            failures++;
            $display("FAIL reset_strength: got %0d want 0", kick_strength);
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_kick_now();
        int s0;
        model_en = 1'b1;
        s0 = strobe_seen;
        issue(2'b00, 8'd40);
        checks++;
        if (kick_strobe !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL kick_now_wait_ready: strobe=%b busy=%b want strobe=0 busy=1",
                     kick_strobe, busy);
        end
        tick();
        checks++;
        if (kick_strobe !== 1'b1 || kick_strength !== 8'd40) begin
            failures++;
            $display("FAIL kick_now_strobe: strobe=%b strength=%0d want 1/40", kick_strobe,
                     kick_strength);
        end
        wait_done("kick_now_done", 40);
        checks++;
        if (kick_lockout !== 1'b0 || kick_fire !== 1'b0) begin
            failures++;
            $display("FAIL kick_now_done_after_lockout: fire=%b lockout=%b want 0/0", kick_fire,
                     kick_lockout);
        end
        tick();
        checks++;
        if (strobe_seen - s0 !== 1 || kick_done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL kick_now_single: strobes=%0d done=%b busy=%b want 1/0/0",
                     strobe_seen - s0, kick_done, busy);
        end
    endtask

    task automatic test_arm_beam();
        int s0;
        s0 = strobe_seen;
        issue(2'b01, 8'd200);
        checks++;
        if (armed !== 1'b1) begin
            failures++;
            $display("FAIL arm_armed: got %b want 1", armed);
        end
        beam_raw = 1'b1;
        repeat (30) tick();
        beam_raw = 1'b0;
        repeat (80) tick();
        checks++;
        if (strobe_seen != s0 || armed !== 1'b1) begin
            failures++;
            $display("FAIL arm_glitch_rejected: strobes=%0d armed=%b want 0/1", strobe_seen - s0,
                     armed);
        end
        beam_raw = 1'b1;
        repeat (70) tick();
        beam_raw = 1'b0;
        wait_done("arm_beam_done", 60);
        checks++;
        if (strobe_seen - s0 !== 1 || last_strength !== 8'd200 || armed !== 1'b0) begin
            failures++;
            $display("FAIL arm_beam_strobe: strobes=%0d strength=%0d armed=%b want 1/200/0",
                     strobe_seen - s0, last_strength, armed);
        end
        repeat (100) tick();
    endtask

    task automatic test_lockout_hold();
        int s0;
        int n;
        s0 = strobe_seen;
        force_lock = 1'b1;
        tick();
        issue(2'b00, 8'd77);
        repeat (20) tick();
        checks++;
        if (strobe_seen != s0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL lockout_hold: strobes=%0d busy=%b want 0/1", strobe_seen - s0, busy);
        end
        force_lock = 1'b0;
        n = 0;
        while (kick_strobe !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        wait_done("lockout_done", 40);
        checks++;
        if (strobe_seen - s0 !== 1 || last_strength !== 8'd77) begin
            failures++;
            $display("FAIL lockout_release_strobe: strobes=%0d strength=%0d want 1/77",
                     strobe_seen - s0, last_strength);
        end
        tick();
    endtask

    task automatic test_arm_timeout();
        int armed_cycles;
        int t_strobes;
        armed_cycles = 0;
        t_strobes = 0;
        cmd_valid_t  = 1'b1;
        cmd_op       = 2'b01;
        cmd_strength = 8'd9;
        tick();
        cmd_valid_t = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if (t_armed === 1'b1) armed_cycles++;
            if (t_strobe === 1'b1) t_strobes++;
            tick();
        end
        checks++;
        if (armed_cycles != 100 || t_strobes != 0 || t_armed !== 1'b0) begin
            failures++;
            $display("FAIL arm_timeout: armed_cycles=%0d strobes=%0d armed=%b want 100/0/0",
                     armed_cycles, t_strobes, t_armed);
        end
    endtask

    task automatic test_strobe_timeout();
        int n;
        model_en   = 1'b0;
        charge_req = 1'b1;
        issue(2'b00, 8'd5);
        n = 0;
        while (kick_strobe !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        repeat (1022) tick();
        checks++;
        if (fault !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_early: fault=%b busy=%b want 0/1", fault, busy);
        end
        repeat (2) tick();
        checks++;
        if (fault !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_fault: fault=%b busy=%b want 1/0", fault, busy);
        end
        tick();
        checks++;
        if (charge_enable !== 1'b0) begin
            failures++;
            $display("FAIL timeout_charge_off: got %b want 0", charge_enable);
        end
        issue(2'b10, 8'd0);
        checks++;
        if (fault !== 1'b0) begin
            failures++;
            $display("FAIL disarm_clears_fault: got %b want 0", fault);
        end
        tick();
        checks++;
        if (charge_enable !== 1'b1) begin
            failures++;
            $display("FAIL charge_after_clear: got %b want 1", charge_enable);
        end
        model_en = 1'b1;
    endtask

    task automatic test_charge();
        charge_req = 1'b1;
        repeat (3) tick();
        checks++;
        if (charge_enable !== 1'b1) begin
            failures++;
            $display("FAIL charge_idle: got %b want 1", charge_enable);
        end
        issue(2'b00, 8'd60);
        tick();
        checks++;
        if (kick_strobe !== 1'b1 || charge_enable !== 1'b0) begin
            failures++;
            $display("FAIL charge_at_strobe: strobe=%b charge=%b want 1/0", kick_strobe,
                     charge_enable);
        end
        wait_done("charge_done", 40);
        checks++;
        if (charge_enable !== 1'b0) begin
            failures++;
            $display("FAIL charge_at_done: got %b want 0", charge_enable);
        end
        tick();
        checks++;
        if (charge_enable !== 1'b1) begin
            failures++;
            $display("FAIL charge_after_done: got %b want 1", charge_enable);
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        int n;
        s0 = strobe_seen;
        issue(2'b00, 8'd11);
        n = 0;
        while (kick_strobe !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        tick();
        issue(2'b00, 8'd99);
        wait_done("b2b_done", 40);
        repeat (10) tick();
        checks++;
        if (strobe_seen - s0 !== 1 || last_strength !== 8'd11 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_dropped: strobes=%0d strength=%0d busy=%b want 1/11/0",
                     strobe_seen - s0, last_strength, busy);
        end
    endtask

    initial begin
        test_reset();
        test_kick_now();
        test_arm_beam();
        test_lockout_hold();
        test_arm_timeout();
        test_back_to_back();
        test_charge();
        test_strobe_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
